sound_playback_scheduler: RTL and testbench
===========================================

# sound_playback_scheduler

Shares the single on-chip sound ROM and the 16-bit audio output among several sound requesters: receive ding, send ding and keystroke click. Generates the sample-rate tick internally, latches request pulses, grants the ROM by fixed priority with preemption, and walks the granted clip's address range one sample per tick. Sits between the messenger text/keyboard logic and the audio codec path.

## Interface
- SAMPLE_DIV, 9072: FPGA_clock cycles per audio sample (50 MHz / 9072 ≈ 5.51 kHz).
- NUM_SRC, 3: number of requesters; index 0 is highest priority.
- CLIP_AW, 12: per-clip sample address width; each clip occupies 2^CLIP_AW words.
- FPGA_clock  in  1  system clock; sole clock of the block.
- FPGA_reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_SRC  single-cycle request pulses: bit0 receive ding, bit1 send ding, bit2 key click.
- clip_len  in  NUM_SRC*CLIP_AW  per-source clip length minus one, static during operation.
- rom_addr  out  2+CLIP_AW  {source id, sample offset} to the synchronous ROM.
- rom_data  in  16  ROM read data, valid one cycle after rom_addr changes.
- audio_out  out  16  current sample (signed), held between samples.
- audio_valid  out  1  one-cycle pulse when audio_out updates.
- active  out  1  high while a clip plays.
- cur_src  out  2  id of the clip playing; 0 when idle.
- done  out  NUM_SRC  one-cycle pulse on the bit of a clip that completes normally.

## Operation
- Tick counter: counts 0..SAMPLE_DIV-1 continuously from reset, free-running; tick is high on the cycle count equals SAMPLE_DIV-1.
- Pending register: req[i] sets pend[i]; pend[i] clears on the cycle source i is granted. A req on a bit that is already pending is absorbed. A req and a grant on the same bit in the same cycle leaves pend set, giving a restart after completion.
- States: IDLE, PLAY.
- IDLE: on tick with any pend set, grant the lowest set index, set offset 0, cur_src = index, go to PLAY. Requests issued between ticks wait for the next tick.
- PLAY, on tick:
  - If a pending source has a lower index than cur_src, preempt: regrant at offset 0 with no done pulse.
  - Otherwise, if offset == clip_len[cur_src], pulse done[cur_src] and apply the IDLE grant rule in the same cycle. Back-to-back clips need no gap tick. With no pending source, go to IDLE with offset 0.
  - Otherwise increment offset.
- Retrigger of the same source while it plays: pend set, and the clip replays after the current one finishes. It does not preempt.
- rom_addr = {cur_src, offset}, registered, so it changes the cycle after tick. rom_data is captured into audio_out one cycle later, with audio_valid pulsing that cycle.
- When IDLE, the tick that enters IDLE causes the following sample to be 16'h0000, with audio_valid still pulsed. Silence then holds at 0.
- Offset width is CLIP_AW and never wraps. clip_len = 0 plays exactly one sample.

## Timing
- Reset values: state IDLE, tick counter 0, pend 0, offset 0, rom_addr 0, audio_out 0, audio_valid 0, active 0, cur_src 0, done 0.
- Reset is asynchronous. Assertion mid-clip silences audio_out immediately and drops all pending requests.
- Latency from tick T:
  - rom_addr, active and cur_src update at T+1.
  - rom_data is valid at T+2.
  - audio_out and audio_valid update at T+3.
  - done asserts at T+1.
- The first sample of a clip appears at T+3 after the granting tick.
- The request-to-grant worst case is SAMPLE_DIV cycles with no contention.

## Structure
- Shared package: source index constants (SRC_RX_DING=0, SRC_TX_DING=1, SRC_KEY_CLICK=2), default SAMPLE_DIV, CLIP_AW, and state encoding.
- Sub-module sample_tick_gen: divider producing the tick enable. All other logic stays in one FSM module. The ROM is external.

## Test plan
- Single request: SAMPLE_DIV=8, clip_len[0]=3, req[0] pulsed → rom_addr offsets 0,1,2,3 on successive ticks. done[0] pulses once, then audio_out returns to 0 and active falls.
- Preemption: clip 2 playing at offset 5, req[0] pulsed → on the next tick rom_addr = {0,0}. There is no done[2]. Clip 2 is not resumed.
- Simultaneous requests: req = 3'b110 in one cycle → clip 1 plays fully and done[1] pulses. Clip 2 starts on the same tick with no idle gap.
- Retrigger: req[1] again mid-clip 1 → clip 1 completes, then replays from offset 0. done[1] pulses twice.
- Reset mid-clip: FPGA_reset_n low at offset 7 → all outputs 0 asynchronously. After release with no requests, the block stays IDLE.
- Boundary: clip_len[2]=0 → exactly one audio_valid with data at offset 0, then done[2].

Source files
------------

// File: rtl/sound_playback_scheduler_pkg.sv
// rtl/sound_playback_scheduler_pkg.sv - shared constants and state encoding for the sound scheduler
package sound_playback_scheduler_pkg;

    localparam int SRC_RX_DING   = 0;
    localparam int SRC_TX_DING   = 1;
    localparam int SRC_KEY_CLICK = 2;

    localparam int SAMPLE_DIV_DEFAULT = 9072;
    localparam int NUM_SRC_DEFAULT    = 3;
    localparam int CLIP_AW_DEFAULT    = 12;
    localparam int SRC_ID_W           = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } sched_state_t;

endpackage

// File: rtl/sound_playback_scheduler_sample_tick_gen.sv
// rtl/sound_playback_scheduler_sample_tick_gen.sv - free-running divider producing the sample-rate tick
module sample_tick_gen #(
    parameter int SAMPLE_DIV = 9072
) (
    input  logic FPGA_clock,
    input  logic FPGA_reset_n,
    output logic tick
);

    localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge FPGA_clock or negedge FPGA_reset_n) begin
        if (!FPGA_reset_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/sound_playback_scheduler.sv
// rtl/sound_playback_scheduler.sv - priority/preemptive scheduler sharing the sound ROM among requesters
module sound_playback_scheduler
    import sound_playback_scheduler_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
    parameter int NUM_SRC    = NUM_SRC_DEFAULT,
    parameter int CLIP_AW    = CLIP_AW_DEFAULT
) (
    input  logic                        FPGA_clock,
    input  logic                        FPGA_reset_n,
    input  logic [NUM_SRC-1:0]          req,
    input  logic [NUM_SRC*CLIP_AW-1:0]  clip_len,
    output logic [SRC_ID_W+CLIP_AW-1:0] rom_addr,
    input  logic [15:0]                 rom_data,
    output logic [15:0]                 audio_out,
    output logic                        audio_valid,
    output logic                        active,
    output logic [SRC_ID_W-1:0]         cur_src,
    output logic [NUM_SRC-1:0]          done
);

    logic                tick;
    sched_state_t        state_q, state_d;
    logic [NUM_SRC-1:0]  pend_q, pend_d, grant;
    logic [CLIP_AW-1:0]  offset_q, offset_d, cur_len;
    logic [SRC_ID_W-1:0] src_q, src_d, low_idx;
    logic [NUM_SRC-1:0]  done_q, done_d;
    logic                any_pend, start_clip, sample_d;
    // Two-stage tags that follow each tick until its ROM word is ready
    logic                smp_d1, smp_d2, sil_d1, sil_d2;

    sample_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick (
        .FPGA_clock   (FPGA_clock),
        .FPGA_reset_n (FPGA_reset_n),
        .tick         (tick)
    );

    assign cur_len  = clip_len[int'(src_q)*CLIP_AW +: CLIP_AW];
    assign any_pend = |pend_q;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx = SRC_ID_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        src_d      = src_q;
        done_d     = '0;
        grant      = '0;
        start_clip = 1'b0;
        sample_d   = 1'b0;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    start_clip = any_pend;
                end
                ST_PLAY: begin
                    sample_d = 1'b1;
                    if (any_pend && (low_idx < src_q)) begin
                        start_clip = 1'b1;
                    end else if (offset_q == cur_len) begin
                        done_d[src_q] = 1'b1;
                        if (any_pend) begin
                            start_clip = 1'b1;
                        end else begin
                            state_d  = ST_IDLE;
                            src_d    = '0;
                            offset_d = '0;
                        end
                    end else begin
                        offset_d = offset_q + CLIP_AW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (start_clip) begin
                grant[low_idx] = 1'b1;
                state_d        = ST_PLAY;
                src_d          = low_idx;
                offset_d       = '0;
                sample_d       = 1'b1;
            end
        end
        // A request landing with its own grant survives, so the clip replays later
        pend_d = (pend_q & ~grant) | req;
    end

    always_ff @(posedge FPGA_clock or negedge FPGA_reset_n) begin
        if (!FPGA_reset_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            offset_q    <= '0;
            src_q       <= '0;
            done_q      <= '0;
            smp_d1      <= 1'b0;
            smp_d2      <= 1'b0;
            sil_d1      <= 1'b0;
            sil_d2      <= 1'b0;
            audio_out   <= '0;
            audio_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            offset_q    <= offset_d;
            src_q       <= src_d;
            done_q      <= done_d;
            smp_d1      <= sample_d;
            smp_d2      <= smp_d1;
            sil_d1      <= (state_d == ST_IDLE);
            sil_d2      <= sil_d1;
            audio_valid <= smp_d2;
            if (smp_d2) begin
                audio_out <= sil_d2 ? 16'h0000 : rom_data;
            end
        end
    end

    assign rom_addr = {src_q, offset_q};
    assign active   = (state_q == ST_PLAY);
    assign cur_src  = src_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sound_playback_scheduler.sv
// tb/tb_sound_playback_scheduler.sv - self-checking bench for sound_playback_scheduler
module tb_sound_playback_scheduler;

    localparam int DIV = 8;
    localparam int NS  = 3;
    localparam int AW  = 12;

    logic              FPGA_clock = 1'b0;
    logic              FPGA_reset_n = 1'b0;
    logic [NS-1:0]     req = '0;
    logic [NS*AW-1:0]  clip_len;
    logic [AW+1:0]     rom_addr;
    logic [15:0]       rom_data = 16'h0000;
    logic [15:0]       audio_out;
    logic              audio_valid;
    logic              active;
    logic [1:0]        cur_src;
    logic [NS-1:0]     done;

    int checks = 0;
    int errors = 0;

    sound_playback_scheduler #(
        .SAMPLE_DIV (DIV),
        .NUM_SRC    (NS),
        .CLIP_AW    (AW)
    ) dut (
        .FPGA_clock   (FPGA_clock),
        .FPGA_reset_n (FPGA_reset_n),
        .req          (req),
        .clip_len     (clip_len),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .audio_out    (audio_out),
        .audio_valid  (audio_valid),
        .active       (active),
        .cur_src      (cur_src),
        .done         (done)
    );

    always #5 FPGA_clock = ~FPGA_clock;

    function automatic logic [15:0] rom_fn(input logic [AW+1:0] a);
        return {2'b01, a};
    endfunction

    always @(posedge FPGA_clock) rom_data <= rom_fn(rom_addr);

    function automatic int lowest(input logic [NS-1:0] p);
        for (int i = 0; i < NS; i++) if (p[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: the playing clip as src/offset ints, samples due three cycles after their tick
    int            m_cnt = 0;
    int            m_src = -1;
    int            m_off = 0;
    int            m_low;
    bit            m_tick, m_was;
    logic [NS-1:0] m_pend = '0;
    logic [NS-1:0] m_done = '0;
    bit            p0v = 0, p1v = 0;
    logic [15:0]   p0d = '0, p1d = '0;
    bit            e_av = 0;
    logic [15:0]   e_ao = '0;

    function automatic logic [AW+1:0] m_addr();
        return (m_src < 0) ? '0 : {2'(m_src), AW'(m_off)};
    endfunction

    always @(posedge FPGA_clock) begin
        if (!FPGA_reset_n) begin
            m_cnt = 0; m_src = -1; m_off = 0; m_pend = '0; m_done = '0;
            p0v = 0; p1v = 0; e_av = 0; e_ao = '0;
        end else begin
            m_tick = (m_cnt == DIV - 1);
            m_cnt  = (m_cnt + 1) % DIV;
            e_av = p1v;
            if (p1v) e_ao = p1d;
            p1v = p0v; p1d = p0d; p0v = 0;
            m_done = '0;
            if (m_tick) begin
                m_low = lowest(m_pend);
                m_was = (m_src >= 0);
                if (m_src < 0 || (m_low >= 0 && m_low < m_src)) begin
                    if (m_low >= 0) begin
                        m_pend[m_low] = 1'b0; m_src = m_low; m_off = 0;
                    end
                end else if (m_off == int'(clip_len[m_src*AW +: AW])) begin
                    m_done[m_src] = 1'b1;
                    if (m_low >= 0) begin
                        m_pend[m_low] = 1'b0; m_src = m_low; m_off = 0;
                    end else begin
                        m_src = -1; m_off = 0;
                    end
                end else begin
                    m_off++;
                end
                if (m_was || m_src >= 0) begin
                    p0v = 1;
                    p0d = (m_src >= 0) ? rom_fn(m_addr()) : 16'h0000;
                end
            end
            m_pend = m_pend | req;
        end
    end

    int n_valid = 0;
    int n_done[NS] = '{0, 0, 0};

    always @(negedge FPGA_clock) begin
        chk("rom_addr", 32'(rom_addr), 32'(m_addr()));
        chk("active", 32'(active), 32'(m_src >= 0));
        chk("cur_src", 32'(cur_src), (m_src < 0) ? 32'd0 : 32'(m_src));
        chk("done", 32'(done), 32'(m_done));
        chk("audio_valid", 32'(audio_valid), 32'(e_av));
        chk("audio_out", 32'(audio_out), 32'(e_ao));
        if (FPGA_reset_n) begin
            n_valid += int'(audio_valid);
            for (int i = 0; i < NS; i++) n_done[i] += int'(done[i]);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge FPGA_clock);
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        @(negedge FPGA_clock);
        req = m;
        @(negedge FPGA_clock);
        req = '0;
    endtask

    task automatic wait_addr(input logic [AW+1:0] a, input int bound);
        int n = 0;
        while (rom_addr !== a && n < bound) begin
            @(negedge FPGA_clock);
            n++;
        end
        chk("wait_addr", 32'(rom_addr), 32'(a));
    endtask

    task automatic wait_clip_end();
        int n = 0;
        while (!active && n < 200) begin @(negedge FPGA_clock); n++; end
        n = 0;
        while (active && n < 800) begin @(negedge FPGA_clock); n++; end
        chk("clip_end", 32'(active), 32'd0);
        cycles(4);
    endtask

    int v0, d0[NS];

    task automatic snap();
        v0 = n_valid;
        for (int i = 0; i < NS; i++) d0[i] = n_done[i];
    endtask

    initial begin
        clip_len = {12'd9, 12'd4, 12'd3};
        cycles(3);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        chk("reset_audio_out", 32'(audio_out), 32'd0);
        chk("reset_active", 32'(active), 32'd0);
        FPGA_reset_n = 1'b1;
        cycles(2);

        snap();
        pulse(3'b001);
        wait_clip_end();
        chk("single_valids", 32'(n_valid - v0), 32'd5);
        chk("single_done0", 32'(n_done[0] - d0[0]), 32'd1);

        snap();
        pulse(3'b100);
        wait_addr({2'd2, 12'd5}, 200);
        pulse(3'b001);
        begin
            int n = 0;
            while (rom_addr == {2'd2, 12'd5} && n < 40) begin @(negedge FPGA_clock); n++; end
        end
        chk("preempt_addr", 32'(rom_addr), 32'h0000);
        wait_clip_end();
        chk("preempt_valids", 32'(n_valid - v0), 32'd11);
        chk("preempt_done2", 32'(n_done[2] - d0[2]), 32'd0);
        chk("preempt_done0", 32'(n_done[0] - d0[0]), 32'd1);

        snap();
        pulse(3'b110);
        wait_clip_end();
        chk("simul_valids", 32'(n_valid - v0), 32'd16);
        chk("simul_done1", 32'(n_done[1] - d0[1]), 32'd1);
        chk("simul_done2", 32'(n_done[2] - d0[2]), 32'd1);

        snap();
        pulse(3'b010);
        wait_addr({2'd1, 12'd2}, 200);
        pulse(3'b010);
        wait_clip_end();
        chk("retrig_valids", 32'(n_valid - v0), 32'd11);
        chk("retrig_done1", 32'(n_done[1] - d0[1]), 32'd2);

        pulse(3'b100);
        wait_addr({2'd2, 12'd7}, 200);
        cycles(4);
        chk("pre_reset_audio", 32'(audio_out), 32'h6007);
        @(negedge FPGA_clock);
        #2 FPGA_reset_n = 1'b0;
        #1;
        chk("async_audio_out", 32'(audio_out), 32'd0);
        chk("async_rom_addr", 32'(rom_addr), 32'd0);
        chk("async_active", 32'(active), 32'd0);
        chk("async_cur_src", 32'(cur_src), 32'd0);
        cycles(3);
        FPGA_reset_n = 1'b1;
        snap();
        cycles(5 * DIV);
        chk("post_reset_idle", 32'(active), 32'd0);
        chk("post_reset_valids", 32'(n_valid - v0), 32'd0);

        clip_len[2*AW +: AW] = 12'd0;
        snap();
        pulse(3'b100);
        begin
            int n = 0;
            while (!audio_valid && n < 60) begin @(negedge FPGA_clock); n++; end
        end
        chk("len0_first_sample", 32'(audio_out), 32'h6000);
        wait_clip_end();
        chk("len0_valids", 32'(n_valid - v0), 32'd2);
        chk("len0_done2", 32'(n_done[2] - d0[2]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
